// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access sequencer.
//   - memAddrMux select encodings (MemAddrCtrl)
//   - access size encodings
//   - sequencer state enum
//   - helper to classify sub-word accesses
package mem_access_ctrl_pkg;

    localparam logic [2:0] SRC_REGA   = 3'd0;
    localparam logic [2:0] SRC_REGB   = 3'd1;
    localparam logic [2:0] SRC_PC     = 3'd2;
    localparam logic [2:0] SRC_ALUOUT = 3'd3;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_WAIT = 3'd1,
        LOAD_WAIT  = 3'd2,
        RMW_READ   = 3'd3,
        RMW_WRITE  = 3'd4
    } state_e;

    // Size 3 is not a sub-word access; it behaves as a word.
    function automatic logic isSubWord(input logic [1:0] sz);
        return (sz == SZ_HALF) || (sz == SZ_BYTE);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Memory wait-state counter.
//   clk, reset : system clock / synchronous active-high reset
//   load       : load loadVal (takes priority over dec)
//   dec        : decrement by one; holds at zero
//   loadVal    : value loaded on entry to a wait state
//   isZero     : count has reached zero
module mem_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    input  logic [2:0] loadVal,
    output logic       isZero
);

    logic [2:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - 3'd1;
        end
    end

    assign isZero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer for the shared memory port.
// Arbitrates store > load > fetch, drives the memAddrMux select and the
// memory write enable, and produces IR/MDR load strobes, the sub-word
// read-modify-write merge strobe and a one-cycle done pulse.
//   clk, reset   : system clock / synchronous active-high reset
//   fetch_req    : instruction fetch request (level)
//   load_req     : data load request (level)
//   store_req    : data store request (level)
//   data_src     : data address source (0=regA, 1=regB, 3=ALUOut, 2 illegal)
//   size         : access size (0=word, 1=half, 2=byte, 3=word)
//   MemAddrCtrl  : memAddrMux select (0=regA, 1=regB, 2=PC, 3=ALUOut)
//   MemWR        : memory write enable
//   IRWrite      : IR load strobe
//   MDRWrite     : MDR load strobe
//   merge_load   : captures old word for sub-word merge
//   busy         : transaction in progress
//   done         : completion pulse
//   err          : illegal data_src rejected
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       load_req,
    input  logic       store_req,
    input  logic [1:0] data_src,
    input  logic [1:0] size,
    output logic [2:0] MemAddrCtrl,
    output logic       MemWR,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       merge_load,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_e state;
    logic   srcLegal;
    logic   cntLoad;
    logic   cntDec;
    logic   cntZero;

    // The counter is only loaded when a transaction with wait states is
    // actually accepted, mirroring the FSM's IDLE decisions below.
    always_comb begin
        srcLegal = ({1'b0, data_src} != SRC_PC);
        cntLoad  = 1'b0;
        cntDec   = 1'b0;
        if (state == IDLE) begin
            if (store_req) begin
                cntLoad = srcLegal && isSubWord(size);
            end else if (load_req) begin
                cntLoad = srcLegal;
            end else begin
                cntLoad = fetch_req;
            end
        end
        if ((state == FETCH_WAIT) || (state == LOAD_WAIT) || (state == RMW_READ)) begin
            cntDec = !cntZero;
        end
    end

    mem_wait_counter waitCnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cntLoad),
        .dec     (cntDec),
        .loadVal (LAT_M1),
        .isZero  (cntZero)
    );

    // Wait states: once the counter reaches zero the strobe is raised for one
    // cycle; the registered strobe itself then marks the exit from the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            MemAddrCtrl <= SRC_PC;
            MemWR       <= 1'b0;
            IRWrite     <= 1'b0;
            MDRWrite    <= 1'b0;
            merge_load  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            MemWR      <= 1'b0;
            IRWrite    <= 1'b0;
            MDRWrite   <= 1'b0;
            merge_load <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (store_req || load_req) begin
                        if (!srcLegal) begin
                            err <= 1'b1;
                        end else begin
                            MemAddrCtrl <= {1'b0, data_src};
                            busy        <= 1'b1;
                            if (!store_req) begin
                                state <= LOAD_WAIT;
                            end else if (isSubWord(size)) begin
                                state <= RMW_READ;
                            end else begin
                                state <= RMW_WRITE;
                                MemWR <= 1'b1;
                                done  <= 1'b1;
                            end
                        end
                    end else if (fetch_req) begin
                        state       <= FETCH_WAIT;
                        MemAddrCtrl <= SRC_PC;
                        busy        <= 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    if (IRWrite) begin
                        state       <= IDLE;
                        MemAddrCtrl <= SRC_PC;
                        busy        <= 1'b0;
                    end else if (cntZero) begin
                        IRWrite <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    if (MDRWrite) begin
                        state       <= IDLE;
                        MemAddrCtrl <= SRC_PC;
                        busy        <= 1'b0;
                    end else if (cntZero) begin
                        MDRWrite <= 1'b1;
                        done     <= 1'b1;
                    end
                end
                RMW_READ: begin
                    if (merge_load) begin
                        state <= RMW_WRITE;
                        MemWR <= 1'b1;
                        done  <= 1'b1;
                    end else if (cntZero) begin
                        merge_load <= 1'b1;
                    end
                end
                RMW_WRITE: begin
                    state       <= IDLE;
                    MemAddrCtrl <= SRC_PC;
                    busy        <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    MemAddrCtrl <= SRC_PC;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. Two instances share stimulus: one with
// MEM_LAT=1 and one with MEM_LAT=3. Each scenario checks one instance.
// Observed vector layout: {MemAddrCtrl[2:0], MemWR, IRWrite, MDRWrite,
// merge_load, busy, done, err}.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_req;
    logic       load_req;
    logic       store_req;
    logic [1:0] data_src;
    logic [1:0] size;

    logic [2:0] mac1, mac3;
    logic       wr1, ir1, mdr1, mrg1, busy1, done1, err1;
    logic       wr3, ir3, mdr3, mrg3, busy3, done3, err3;

    logic [9:0] o1, o3;
    assign o1 = {mac1, wr1, ir1, mdr1, mrg1, busy1, done1, err1};
    assign o3 = {mac3, wr3, ir3, mdr3, mrg3, busy3, done3, err3};

    int vecs = 0;
    int errs = 0;

    localparam logic [9:0] IDLE_O = 10'b010_0000000;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .load_req(load_req),
        .store_req(store_req), .data_src(data_src), .size(size),
        .MemAddrCtrl(mac1), .MemWR(wr1), .IRWrite(ir1), .MDRWrite(mdr1),
        .merge_load(mrg1), .busy(busy1), .done(done1), .err(err1)
    );

    mem_access_ctrl #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .load_req(load_req),
        .store_req(store_req), .data_src(data_src), .size(size),
        .MemAddrCtrl(mac3), .MemWR(wr3), .IRWrite(ir3), .MDRWrite(mdr3),
        .merge_load(mrg3), .busy(busy3), .done(done3), .err(err3)
    );

    // Advance one cycle; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1; fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
        data_src = 2'd0; size = 2'd0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        vecs++; if (o1 !== IDLE_O) begin errs++; $display("FAIL reset dut1: got %b want %b", o1, IDLE_O); end
        vecs++; if (o3 !== IDLE_O) begin errs++; $display("FAIL reset dut3: got %b want %b", o3, IDLE_O); end
    endtask

    task automatic test_fetch();
        doReset();
        fetch_req = 1'b1;
        tick();
        vecs++; if (o1 !== 10'b010_0000100) begin errs++; $display("FAIL fetch c1: got %b want %b", o1, 10'b010_0000100); end
        tick();
        vecs++; if (o1 !== 10'b010_0100110) begin errs++; $display("FAIL fetch c2: got %b want %b", o1, 10'b010_0100110); end
        fetch_req = 1'b0;
        tick();
        vecs++; if (o1 !== IDLE_O) begin errs++; $display("FAIL fetch c3: got %b want %b", o1, IDLE_O); end
    endtask

    task automatic test_load_priority();
        doReset();
        load_req = 1'b1; fetch_req = 1'b1; data_src = 2'd3;
        tick();
        vecs++; if (o1 !== 10'b011_0000100) begin errs++; $display("FAIL loadprio c1: got %b want %b", o1, 10'b011_0000100); end
        tick();
        vecs++; if (o1 !== 10'b011_0010110) begin errs++; $display("FAIL loadprio c2: got %b want %b", o1, 10'b011_0010110); end
        load_req = 1'b0;
        tick();
        vecs++; if (o1 !== IDLE_O) begin errs++; $display("FAIL loadprio c3: got %b want %b", o1, IDLE_O); end
        tick();
        vecs++; if (o1 !== 10'b010_0000100) begin errs++; $display("FAIL loadprio c4: got %b want %b", o1, 10'b010_0000100); end
        tick();
        vecs++; if (o1 !== 10'b010_0100110) begin errs++; $display("FAIL loadprio c5: got %b want %b", o1, 10'b010_0100110); end
        fetch_req = 1'b0;
        tick();
        vecs++; if (o1 !== IDLE_O) begin errs++; $display("FAIL loadprio c6: got %b want %b", o1, IDLE_O); end
    endtask

    task automatic test_word_store();
        doReset();
        store_req = 1'b1; size = 2'd0; data_src = 2'd1;
        tick();
        vecs++; if (o1 !== 10'b001_1000110) begin errs++; $display("FAIL wstore c1: got %b want %b", o1, 10'b001_1000110); end
        store_req = 1'b0;
        tick();
        vecs++; if (o1 !== IDLE_O) begin errs++; $display("FAIL wstore c2: got %b want %b", o1, IDLE_O); end
    endtask

    task automatic test_subword_store();
        doReset();
        store_req = 1'b1; size = 2'd2; data_src = 2'd0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            // source/size changes after accept must be ignored
            if (c == 2) begin data_src = 2'd1; size = 2'd0; end
            vecs++; if (o3 !== 10'b000_0000100) begin errs++; $display("FAIL rmw c%0d: got %b want %b", c, o3, 10'b000_0000100); end
        end
        tick();
        vecs++; if (o3 !== 10'b000_0001100) begin errs++; $display("FAIL rmw c4: got %b want %b", o3, 10'b000_0001100); end
        tick();
        vecs++; if (o3 !== 10'b000_1000110) begin errs++; $display("FAIL rmw c5: got %b want %b", o3, 10'b000_1000110); end
        store_req = 1'b0;
        tick();
        vecs++; if (o3 !== IDLE_O) begin errs++; $display("FAIL rmw c6: got %b want %b", o3, IDLE_O); end
    endtask

    task automatic test_err();
        doReset();
        load_req = 1'b1; data_src = 2'd2; fetch_req = 1'b1;
        tick();
        vecs++; if (o1 !== 10'b010_0000001) begin errs++; $display("FAIL err c1: got %b want %b", o1, 10'b010_0000001); end
        load_req = 1'b0;
        tick();
        vecs++; if (o1 !== 10'b010_0000100) begin errs++; $display("FAIL err c2: got %b want %b", o1, 10'b010_0000100); end
        tick();
        vecs++; if (o1 !== 10'b010_0100110) begin errs++; $display("FAIL err c3: got %b want %b", o1, 10'b010_0100110); end
        fetch_req = 1'b0;
        tick();
        vecs++; if (o1 !== IDLE_O) begin errs++; $display("FAIL err c4: got %b want %b", o1, IDLE_O); end
    endtask

    task automatic test_reset_mid();
        doReset();
        store_req = 1'b1; size = 2'd1; data_src = 2'd1;
        tick();
        vecs++; if (o3 !== 10'b001_0000100) begin errs++; $display("FAIL rstmid c1: got %b want %b", o3, 10'b001_0000100); end
        tick();
        vecs++; if (o3 !== 10'b001_0000100) begin errs++; $display("FAIL rstmid c2: got %b want %b", o3, 10'b001_0000100); end
        reset = 1'b1;
        tick();
        reset = 1'b0; store_req = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            vecs++; if (o3 !== IDLE_O) begin errs++; $display("FAIL rstmid c%0d: got %b want %b", c, o3, IDLE_O); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        store_req = 1'b1; size = 2'd3; data_src = 2'd3;
        tick();
        vecs++; if (o1 !== 10'b011_1000110) begin errs++; $display("FAIL b2b c1: got %b want %b", o1, 10'b011_1000110); end
        tick();
        vecs++; if (o1 !== IDLE_O) begin errs++; $display("FAIL b2b c2: got %b want %b", o1, IDLE_O); end
        tick();
        vecs++; if (o1 !== 10'b011_1000110) begin errs++; $display("FAIL b2b c3: got %b want %b", o1, 10'b011_1000110); end
        store_req = 1'b0;
        tick();
        vecs++; if (o1 !== IDLE_O) begin errs++; $display("FAIL b2b c4: got %b want %b", o1, IDLE_O); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load_priority();
        test_word_store();
        test_subword_store();
        test_err();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer for the shared memory port: arbitrates instruction fetch vs. data load/store requests and drives memAddrMux's select (MemAddrCtrl).
- Also drives memory write enable, IR/MDR load strobes, and read-modify-write for sub-word stores.
- Sits between the main control FSM and the memory/memAddrMux datapath; lets the main FSM issue one request and wait for done instead of hand-counting memory wait states.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from address stable to read data usable (legal 1..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  instruction-fetch request (level).
- load_req  in  1  data-load request (level).
- store_req  in  1  data-store request (level).
- data_src  in  2  data-address source: 0=regA, 1=regB, 3=ALUOut; 2 is illegal.
- size  in  2  access size: 0=word, 1=half, 2=byte; 3 is treated as word.
- MemAddrCtrl  out  3  memAddrMux select: 0=regA, 1=regB, 2=PC, 3=ALUOut.
- MemWR  out  1  memory write enable.
- IRWrite  out  1  one-cycle strobe; loads IR from memory data.
- MDRWrite  out  1  one-cycle strobe; loads MDR from memory data.
- merge_load  out  1  one-cycle strobe; captures the old word for sub-word merge.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse; illegal data_src rejected.

Behaviour:
- Reset values: MemAddrCtrl=2 (PC); MemWR, IRWrite, MDRWrite, merge_load, done, err = 0; busy=0; state=IDLE; wait counter=0.
- All outputs are registered.
- States: IDLE, FETCH_WAIT, LOAD_WAIT, RMW_READ, RMW_WRITE.
- Requests are sampled only in IDLE.
- Arbitration priority: store > load > fetch. Losers are not queued; they stay pending because requests are level.
- Illegal data_src on load/store (accepting edge k):
  - err=1 for cycle k+1, no memory access, stay IDLE.
  - A simultaneous fetch_req is still not served that edge.
- Fetch accepted at edge k:
  - MemAddrCtrl=2 from cycle k+1.
  - Counter runs MEM_LAT cycles.
  - IRWrite=1 and done=1 together for exactly one cycle, starting at edge k+MEM_LAT+1.
  - Return to IDLE.
- Load accepted at edge k:
  - MemAddrCtrl=data_src (captured at k) from cycle k+1.
  - MDRWrite=1 and done=1 for one cycle at edge k+MEM_LAT+1. Size is irrelevant to this block.
- Word store accepted at edge k:
  - MemAddrCtrl=src and MemWR=1 for exactly one cycle (cycle k+1), with done=1 in the same cycle.
  - Return to IDLE; no wait states.
- Sub-word store (size 1 or 2) accepted at edge k:
  - RMW_READ: MemAddrCtrl=src, MemWR=0, wait MEM_LAT cycles. merge_load=1 for one cycle at edge k+MEM_LAT+1.
  - RMW_WRITE, next cycle: MemWR=1 and done=1 for one cycle, address unchanged.
  - Total occupancy: MEM_LAT+2 cycles.
- MemAddrCtrl is held constant for the whole transaction. In IDLE it returns to 2 (PC).
- MemWR is never high in any state other than the single write cycle.
- Requester drops its request in the done cycle. If it is still high at the next IDLE sample, it is re-served; this is legal and gives back-to-back transactions with one IDLE cycle between them.
- Changes to data_src or size mid-transaction are ignored; they are captured at accept.
- Reset mid-transaction:
  - Abort immediately at that edge; no MemWR, no strobes, no done.
  - Outputs go to reset values on the following cycle.
- Wait counter: 3-bit, loaded with MEM_LAT-1 on entry, decremented to 0. No wrap past 0.

Decomposition:
- Shared package holds:
  - MemAddrCtrl encodings (SRC_REGA=0, SRC_REGB=1, SRC_PC=2, SRC_ALUOUT=3).
  - Size encodings (SZ_WORD, SZ_HALF, SZ_BYTE).
  - State enum.
- Sub-module mem_wait_counter (load/decrement/zero flag).
- Top-level mem_access_ctrl holds the arbiter and FSM.

Test Plan:
- Reset, then fetch_req=1 (MEM_LAT=1):
  - MemAddrCtrl=2 cycles 1-2; IRWrite=done=1 in cycle 2 only.
  - busy high cycles 1-2; MemWR stays 0.
- load_req=1, data_src=3, fetch_req=1 same edge: load wins, MemAddrCtrl=3, MDRWrite pulse after MEM_LAT+1. Then fetch served after one IDLE cycle with MemAddrCtrl=2.
- store_req=1, size=0, data_src=1: MemAddrCtrl=1 and MemWR=1 for exactly one cycle, done in the same cycle.
- store_req=1, size=2, data_src=0, MEM_LAT=3:
  - merge_load at cycle 4, then MemWR=done=1 at cycle 5.
  - MemAddrCtrl=0 throughout, MemWR=0 in cycles 1-4.
- load_req=1, data_src=2: err pulse one cycle, no MDRWrite/MemWR, busy stays 0.
- Sub-word store with reset asserted in cycle 2 of RMW_READ: no MemWR ever, no done; outputs at reset values (MemAddrCtrl=2) afterwards.
